// File: rtl/jtag_debug_cmd_capture.sv
// Sysclk-side capture stage for the JTAG debug module.
// Synchronises the update-DR / update-IR strobes from the TCK domain, queues
// {ir, dr} snapshots in a small FIFO and releases them to the debug core with
// a registered jdo word and one-hot take-action pulses.

// Strobe synchroniser: STAGES flops plus an edge flop, all resetting to 1 so a
// strobe held high across reset release must go low before it can rise again.
module jtag_dbg_strobe_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_level,
   output logic o_rise
);

   logic [STAGES-1:0] r_sync;
   logic              r_edge;

   // Shift the asynchronous level through the chain and remember the last stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= '1;
         r_edge <= 1'b1;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_level};
         r_edge <= r_sync[STAGES-1];
      end
   end

   assign o_rise = r_sync[STAGES-1] & ~r_edge;

endmodule

module jtag_debug_cmd_capture #(
   parameter int IR_W        = 2,
   parameter int DR_W        = 38,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int ACTION_BIT  = 35
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          vs_udr,
   input  logic                          vs_uir,
   input  logic [IR_W-1:0]               ir_in,
   input  logic [DR_W-1:0]               sr,
   input  logic                          cmd_ready,
   input  logic                          overflow_clr,
   output logic                          cmd_valid,
   output logic [IR_W-1:0]               cmd_ir,
   output logic [DR_W-1:0]               cmd_data,
   output logic [DR_W-1:0]               jdo,
   output logic [(1<<IR_W)-1:0]          take_action,
   output logic [(1<<IR_W)-1:0]          take_no_action,
   output logic                          ir_update,
   output logic [IR_W-1:0]               ir_latched,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int N_INSTR = 1 << IR_W;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int ENT_W   = IR_W + DR_W;

   logic                 w_udr_rise;
   logic                 w_uir_rise;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_push_ok;
   logic                 w_drop;
   logic [ENT_W-1:0]     w_head;
   logic [N_INSTR-1:0]   w_sel;

   logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [LVL_W-1:0]     r_level;
   logic                 r_overflow;
   logic [DR_W-1:0]      r_jdo;
   logic [N_INSTR-1:0]   r_take_action;
   logic [N_INSTR-1:0]   r_take_no_action;
   logic                 r_ir_update;
   logic [IR_W-1:0]      r_ir_latched;

   jtag_dbg_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_udr (
      .clk     (clk),
      .reset   (reset),
      .i_level (vs_udr),
      .o_rise  (w_udr_rise)
   );

   jtag_dbg_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_uir (
      .clk     (clk),
      .reset   (reset),
      .i_level (vs_uir),
      .o_rise  (w_uir_rise)
   );

   // When full, a simultaneous pop frees the slot the push lands in (wr == rd),
   // so the write and the head read happen on the same entry without conflict.
   assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
   assign cmd_valid = (r_level != '0);
   assign w_pop     = cmd_valid & cmd_ready;
   assign w_push_ok = w_udr_rise & (~w_full | w_pop);
   assign w_drop    = w_udr_rise & w_full & ~w_pop;

   assign w_head    = r_mem[r_rd_ptr];
   assign cmd_ir    = w_head[ENT_W-1:DR_W];
   assign cmd_data  = w_head[DR_W-1:0];
   assign w_sel     = N_INSTR'(1) << cmd_ir;

   // Command storage; contents need no reset because level gates visibility.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= {ir_in, sr};
      end
   end

   // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push_ok && !w_pop) begin
            r_level <= r_level + LVL_W'(1);
         end else if (w_pop && !w_push_ok) begin
            r_level <= r_level - LVL_W'(1);
         end
      end
   end

   // Sticky overflow; a new drop wins over a clear in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (overflow_clr) begin
         r_overflow <= 1'b0;
      end
   end

   // Pop side effects: latch jdo and fire one pulse selected by the action bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_jdo            <= '0;
         r_take_action    <= '0;
         r_take_no_action <= '0;
      end else begin
         r_take_action    <= '0;
         r_take_no_action <= '0;
         if (w_pop) begin
            r_jdo <= cmd_data;
            if (cmd_data[ACTION_BIT]) begin
               r_take_action <= w_sel;
            end else begin
               r_take_no_action <= w_sel;
            end
         end
      end
   end

   // IR update: capture ir_in and pulse once per synchronised vs_uir rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ir_update  <= 1'b0;
         r_ir_latched <= '0;
      end else begin
         r_ir_update <= w_uir_rise;
         if (w_uir_rise) begin
            r_ir_latched <= ir_in;
         end
      end
   end

   assign fifo_level     = r_level;
   assign overflow       = r_overflow;
   assign jdo            = r_jdo;
   assign take_action    = r_take_action;
   assign take_no_action = r_take_no_action;
   assign ir_update      = r_ir_update;
   assign ir_latched     = r_ir_latched;

endmodule
